shake_squeeze_buffer: RTL and testbench
=======================================

// Module: shake_squeeze_buffer
// PURPOSE
//  Downstream neighbour of the permute datapath. Captures one rate block per squeeze and emits it as DOUT_W-bit words over a valid/ready stream.
//  Counts the requested output length in bits, zero-masks the tail of the final word and flags the last word.
//  Tells the control FSM when another permutation is needed to produce more output.
// PARAMETERS
//  RATE_W  1344  captured block width; equals RATE_SHAKE128, the widest rate
//  DOUT_W  64    output word width; equals lane width w; RATE_SHAKE128/RATE_SHAKE256 are multiples of it
// PORTS
//  clk             in   1       clock
//  rst             in   1       reset, asynchronous, active-high
//  blk_valid       in   1       permute stage offers a squeezed rate block
//  blk_ready       out  1       buffer can accept a block
//  blk_first       in   1       block is first of a new request; qualified by blk_valid
//  rate_block      in   RATE_W  state rate bits; bit 0 = first output bit
//  operation_mode  in   2       SHAKE128_MODE_VEC / SHAKE256_MODE_VEC; sampled with blk_first
//  output_size     in   32      requested output length in bits; sampled with blk_first
//  dout_valid      out  1       dout holds a valid word
//  dout_ready      in   1       sink accepts word
//  dout            out  DOUT_W  output word
//  dout_last       out  1       dout is the final word of the request
//  squeeze_more    out  1       request unfinished, buffer empty: permute another block
//  request_done    out  1       1-cycle pulse when a request completes
//  mode_err        out  1       sticky: block_first with an unsupported mode
// BEHAVIOUR
//  Reset (async): FSM=IDLE, all counters 0, blk_ready=1, dout_valid=0, dout=0, dout_last=0, squeeze_more=0, request_done=0, mode_err=0.
//  Blocks are accepted when blk_valid & blk_ready. Accepted rate_block is registered into buf, and dout is driven from buf.
//  On accept with blk_first=1:
//    - mode_reg <= operation_mode.
//    - words_left <= ceil(output_size/DOUT_W), 27-bit.
//    - tail_bits <= output_size mod DOUT_W.
//  On accept with blk_first=0: mode_reg, words_left and tail_bits are kept.
//  Words per block NW: 21 for SHAKE128, 17 for SHAKE256 (rate/DOUT_W). Mode is the new operation_mode on a first block, otherwise mode_reg.
//  FSM states:
//    IDLE:  blk_ready=1.
//      - Accept with words_left' > 0 and valid mode -> DRAIN, word_idx <= 0.
//      - Accept with words_left' = 0 -> stay IDLE, pulse request_done next cycle; block discarded.
//      - Accept with invalid mode -> stay IDLE, set mode_err, clear words_left; block discarded, no done pulse.
//    DRAIN: blk_ready=0, dout_valid=1, dout = buf[word_idx*DOUT_W +: DOUT_W].
//      dout_last = (words_left == 1). On the last word, bits at or above tail_bits are forced 0 when tail_bits != 0.
//      On each dout_valid & dout_ready:
//        - word_idx++ and words_left--.
//        - If words_left was 1: -> IDLE, request_done=1 next cycle.
//        - Else if word_idx was NW-1: -> IDLE.
//        - Else stay in DRAIN.
//  squeeze_more = (state == IDLE) & (words_left != 0). Registered, so it is valid the cycle after DRAIN exits.
//  Latency: block accept -> first dout_valid is 1 cycle. One word per cycle while dout_ready=1.
//  dout, dout_last: held stable while dout_valid & !dout_ready.
//  blk_first while a request is active (words_left != 0, in IDLE): the new request overrides and the old remainder is dropped.
//  dout_valid never drops without a handshake, except on rst.
//  Async rst mid-DRAIN: outputs go to reset values immediately. Any partial request is lost.
//  output_size of up to 2^32-1 is supported. words_left never wraps; it decrements only when nonzero.
// TESTING
//  T1 SHAKE128, output_size=256, dout_ready=1:
//     -> 4 words = rate_block[255:0] in order, last on word 3, request_done pulse, squeeze_more stays 0.
//  T2 SHAKE256, output_size=1088*2+64:
//     -> 17 words, squeeze_more=1, next block gives 17 words, third block gives 1 word with dout_last; 35 words total.
//  T3 SHAKE128, output_size=100:
//     -> 2 words; word 1 bits [63:36] = 0, bits [35:0] = rate_block[99:64]; dout_last on word 1.
//  T4 output_size=0 with blk_first:
//     -> block accepted, no dout_valid, request_done pulses once.
//  T5 random dout_ready backpressure, SHAKE128, output_size=1344*3:
//     -> 63 words, dout stable under stall, no loss or duplication.
//  T6 rst asserted mid-DRAIN (word 5):
//     -> dout_valid=0 asynchronously, blk_ready=1; a new request after release drains correctly. Invalid mode sets mode_err.

Source files
------------

// File: rtl/shake_squeeze_buffer.sv
// shake_squeeze_buffer
// Captures one squeezed rate block and streams it out as DOUT_W-bit words.
// Tracks the requested output length, zero-masks the unused tail of the final
// word and asks the control FSM for another permutation when more output is owed.
module shake_squeeze_buffer #(
    parameter int         RATE_W            = 1344,
    parameter int         DOUT_W            = 64,
    parameter logic [1:0] SHAKE128_MODE_VEC = 2'b01,
    parameter logic [1:0] SHAKE256_MODE_VEC = 2'b10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic              blk_first,
    input  logic [RATE_W-1:0] rate_block,
    input  logic [1:0]        operation_mode,
    input  logic [31:0]       output_size,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_last,
    output logic              squeeze_more,
    output logic              request_done,
    output logic              mode_err
);

    // Word-count arithmetic: a 32-bit bit length rounded up to whole words
    // needs 33 - log2(DOUT_W) bits, so the count can never overflow.
    localparam int OFF_W = $clog2(DOUT_W);
    localparam int WL_W  = 33 - OFF_W;
    localparam int NW128 = RATE_W / DOUT_W;
    localparam int NW256 = 1088 / DOUT_W;
    localparam int IDX_W = $clog2(NW128 + 1);

    localparam logic [IDX_W-1:0] NW128_LAST = IDX_W'(NW128 - 1);
    localparam logic [IDX_W-1:0] NW256_LAST = IDX_W'(NW256 - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [RATE_W-1:0] blockBuf_q, blockBuf_d;
    logic [IDX_W-1:0]  wordIdx_q, wordIdx_d;
    logic [WL_W-1:0]   wordsLeft_q, wordsLeft_d;
    logic [OFF_W-1:0]  tailBits_q, tailBits_d;
    logic [1:0]        modeReg_q, modeReg_d;
    logic              requestDone_q, requestDone_d;
    logic              squeezeMore_q, squeezeMore_d;
    logic              modeErr_q, modeErr_d;

    logic              blkAccept;
    logic [1:0]        effMode;
    logic              effModeValid;
    logic [32:0]       sizeRounded;
    logic [WL_W-1:0]   wordsFromSize;
    logic [WL_W-1:0]   wordsLeftNew;
    logic [IDX_W-1:0]  lastIdx;
    logic              lastWord;
    int                wordOffset;
    logic [DOUT_W-1:0] rawWord;
    logic [DOUT_W-1:0] tailMask;

    assign blkAccept     = blk_valid & (state_q == IDLE);
    assign effMode       = blk_first ? operation_mode : modeReg_q;
    assign effModeValid  = (effMode == SHAKE128_MODE_VEC) || (effMode == SHAKE256_MODE_VEC);
    assign sizeRounded   = {1'b0, output_size} + 33'(DOUT_W - 1);
    assign wordsFromSize = sizeRounded[32:OFF_W];
    assign wordsLeftNew  = blk_first ? wordsFromSize : wordsLeft_q;
    assign lastIdx       = (modeReg_q == SHAKE256_MODE_VEC) ? NW256_LAST : NW128_LAST;
    assign lastWord      = (wordsLeft_q == WL_W'(1));

    // State and datapath registers; reset clears everything, dropping any partial request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            blockBuf_q    <= '0;
            wordIdx_q     <= '0;
            wordsLeft_q   <= '0;
            tailBits_q    <= '0;
            modeReg_q     <= '0;
            requestDone_q <= 1'b0;
            squeezeMore_q <= 1'b0;
            modeErr_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            blockBuf_q    <= blockBuf_d;
            wordIdx_q     <= wordIdx_d;
            wordsLeft_q   <= wordsLeft_d;
            tailBits_q    <= tailBits_d;
            modeReg_q     <= modeReg_d;
            requestDone_q <= requestDone_d;
            squeezeMore_q <= squeezeMore_d;
            modeErr_q     <= modeErr_d;
        end
    end

    // Next-state logic: block capture in IDLE, one word per handshake in DRAIN.
    always_comb begin
        state_d       = state_q;
        blockBuf_d    = blockBuf_q;
        wordIdx_d     = wordIdx_q;
        wordsLeft_d   = wordsLeft_q;
        tailBits_d    = tailBits_q;
        modeReg_d     = modeReg_q;
        requestDone_d = 1'b0;
        modeErr_d     = modeErr_q;

        case (state_q)
            IDLE: begin
                if (blkAccept) begin
                    blockBuf_d = rate_block;
                    if (blk_first) begin
                        modeReg_d   = operation_mode;
                        tailBits_d  = output_size[OFF_W-1:0];
                        wordsLeft_d = wordsFromSize;
                    end
                    if (!effModeValid) begin
                        modeErr_d   = 1'b1;
                        wordsLeft_d = '0;
                    end else if (wordsLeftNew == '0) begin
                        requestDone_d = 1'b1;
                    end else begin
                        state_d   = DRAIN;
                        wordIdx_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (dout_ready) begin
                    wordIdx_d = wordIdx_q + IDX_W'(1);
                    if (wordsLeft_q != '0) begin
                        wordsLeft_d = wordsLeft_q - WL_W'(1);
                    end
                    if (lastWord) begin
                        state_d       = IDLE;
                        requestDone_d = 1'b1;
                    end else if (wordIdx_q == lastIdx) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        squeezeMore_d = (state_d == IDLE) && (wordsLeft_d != '0);
    end

    // Output decode: word select from the captured block with tail masking on the final word.
    always_comb begin
        wordOffset = int'(wordIdx_q) * DOUT_W;
        rawWord    = blockBuf_q[wordOffset +: DOUT_W];
        tailMask   = ~({DOUT_W{1'b1}} << tailBits_q);
        if (lastWord && (tailBits_q != '0)) begin
            rawWord = rawWord & tailMask;
        end
        blk_ready    = (state_q == IDLE);
        dout_valid   = (state_q == DRAIN);
        dout_last    = (state_q == DRAIN) && lastWord;
        dout         = (state_q == DRAIN) ? rawWord : '0;
        squeeze_more = squeezeMore_q;
        request_done = requestDone_q;
        mode_err     = modeErr_q;
    end

endmodule

// File: tb/tb_shake_squeeze_buffer.sv
// tb_shake_squeeze_buffer
// Randomized requests against a word-level reference model; expected words are
// queued by the driver and consumed by an independent output monitor.
module tb_shake_squeeze_buffer;

    localparam int         RATE_W = 1344;
    localparam int         DOUT_W = 64;
    localparam logic [1:0] M128   = 2'b01;
    localparam logic [1:0] M256   = 2'b10;
    localparam logic [1:0] MBAD   = 2'b11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              blk_valid = 1'b0;
    logic              blk_ready;
    logic              blk_first = 1'b0;
    logic [RATE_W-1:0] rate_block = '0;
    logic [1:0]        operation_mode = M128;
    logic [31:0]       output_size = '0;
    logic              dout_valid;
    logic              dout_ready = 1'b1;
    logic [DOUT_W-1:0] dout;
    logic              dout_last;
    logic              squeeze_more;
    logic              request_done;
    logic              mode_err;

    shake_squeeze_buffer #(
        .RATE_W(RATE_W),
        .DOUT_W(DOUT_W),
        .SHAKE128_MODE_VEC(M128),
        .SHAKE256_MODE_VEC(M256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_first(blk_first),
        .rate_block(rate_block),
        .operation_mode(operation_mode),
        .output_size(output_size),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout(dout),
        .dout_last(dout_last),
        .squeeze_more(squeeze_more),
        .request_done(request_done),
        .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DOUT_W-1:0] data;
        logic              last;
    } expWord_t;

    expWord_t          expQ[$];
    int                checks = 0;
    int                passes = 0;
    int                popCount = 0;
    int                doneSeen = 0;
    logic              bpEnable = 1'b0;
    logic              stallPending = 1'b0;
    logic [DOUT_W-1:0] heldData = '0;
    logic              heldLast = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Sink readiness: always ready, or randomly stalled when backpressure is on.
    always begin
        @(posedge clk);
        #1;
        dout_ready = bpEnable ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Output monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stallPending = 1'b0;
        end else begin
            if (stallPending) begin
                checkOutput("stall_valid_held", dout_valid, 1);
                checkOutput("stall_data_held", dout, heldData);
                checkOutput("stall_last_held", dout_last, heldLast);
            end
            stallPending = dout_valid && !dout_ready;
            heldData = dout;
            heldLast = dout_last;
            if (dout_valid && dout_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_word", dout_valid, 0);
                end else begin
                    expWord_t e;
                    e = expQ.pop_front();
                    checkOutput("dout_data", dout, e.data);
                    checkOutput("dout_last", dout_last, e.last);
                    popCount++;
                end
            end
            if (request_done) doneSeen++;
        end
    end

    // Runaway guard.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic randomBlock(output logic [RATE_W-1:0] blk);
        for (int k = 0; k < RATE_W / 32; k++) blk[k*32 +: 32] = $urandom();
    endtask

    // Reference model: output word g of a request is word (g mod NW) of block (g div NW).
    task automatic pushBlockWords(input logic [RATE_W-1:0] blk, input int nw, input longint total,
                                  input int tail, inout longint g);
        for (int i = 0; i < nw && g < total; i++) begin
            expWord_t e;
            e.data = blk[i*DOUT_W +: DOUT_W];
            e.last = (g == total - 1);
            if (e.last && tail != 0) e.data = e.data & ((64'd1 << tail) - 64'd1);
            expQ.push_back(e);
            g++;
        end
    endtask

    task automatic offerBlock(input logic [RATE_W-1:0] blk, input logic first,
                              input logic [1:0] mode, input logic [31:0] size);
        int n = 0;
        @(posedge clk);
        #1;
        rate_block     = blk;
        blk_first      = first;
        operation_mode = mode;
        output_size    = size;
        blk_valid      = 1'b1;
        @(negedge clk);
        while (!blk_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("blk_ready_wait", blk_ready, 1);
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        blk_first = 1'b0;
    endtask

    task automatic waitSqueeze();
        int n = 0;
        @(negedge clk);
        while (!squeeze_more && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("squeeze_more_wait", squeeze_more, 1);
        checkOutput("queue_empty_at_squeeze", expQ.size(), 0);
    endtask

    // One complete request: model the expected words, feed blocks on demand, await completion.
    task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] size);
        int     nw = (mode == M256) ? 1088 / DOUT_W : RATE_W / DOUT_W;
        longint total = (longint'(size) + DOUT_W - 1) / DOUT_W;
        int     tail = int'(size % DOUT_W);
        longint nblk = (total + nw - 1) / nw;
        longint g = 0;
        int     doneBefore = doneSeen;
        int     n = 0;
        logic [RATE_W-1:0] blk;
        if (nblk == 0) nblk = 1;
        for (longint b = 0; b < nblk; b++) begin
            randomBlock(blk);
            if (b > 0) waitSqueeze();
            pushBlockWords(blk, nw, total, tail, g);
            offerBlock(blk, b == 0, mode, size);
        end
        while (!(expQ.size() == 0 && doneSeen > doneBefore) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checkOutput("request_words_drained", expQ.size(), 0);
        checkOutput("request_done_count", doneSeen - doneBefore, 1);
        checkOutput("squeeze_more_after_done", squeeze_more, 0);
    endtask

    initial begin
        logic [RATE_W-1:0] blk;
        longint g;
        int doneBefore;
        int popBase;
        int n;

        // Reset values while reset is held.
        #12;
        checkOutput("reset_blk_ready", blk_ready, 1);
        checkOutput("reset_dout_valid", dout_valid, 0);
        checkOutput("reset_dout", dout, 0);
        checkOutput("reset_dout_last", dout_last, 0);
        checkOutput("reset_squeeze_more", squeeze_more, 0);
        checkOutput("reset_request_done", request_done, 0);
        checkOutput("reset_mode_err", mode_err, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] T1 SHAKE128 256 bits");
        applyStimulus(M128, 256);
        $display("[TB] T3 SHAKE128 100 bits");
        applyStimulus(M128, 100);
        $display("[TB] T4 zero-length request");
        applyStimulus(M128, 0);
        $display("[TB] T2 SHAKE256 three blocks");
        applyStimulus(M256, 1088 * 2 + 64);

        $display("[TB] T5 backpressure");
        bpEnable = 1'b1;
        applyStimulus(M128, 1344 * 3);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(($urandom_range(0, 1) != 0) ? M128 : M256, $urandom_range(1, 3000));
        end
        bpEnable = 1'b0;

        $display("[TB] override of an unfinished request");
        randomBlock(blk);
        g = 0;
        pushBlockWords(blk, RATE_W / DOUT_W, 32, 2000 % DOUT_W, g);
        offerBlock(blk, 1'b1, M128, 2000);
        waitSqueeze();
        applyStimulus(M128, 128);

        $display("[TB] unsupported mode");
        doneBefore = doneSeen;
        randomBlock(blk);
        offerBlock(blk, 1'b1, MBAD, 256);
        repeat (4) @(negedge clk);
        checkOutput("mode_err_set", mode_err, 1);
        checkOutput("mode_err_no_done", doneSeen, doneBefore);
        checkOutput("mode_err_no_squeeze", squeeze_more, 0);

        $display("[TB] T6 reset mid-drain");
        randomBlock(blk);
        g = 0;
        popBase = popCount;
        pushBlockWords(blk, RATE_W / DOUT_W, 21, 0, g);
        offerBlock(blk, 1'b1, M128, 1344);
        n = 0;
        while (popCount < popBase + 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_words_before_reset", popCount - popBase, 5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_dout_valid_async", dout_valid, 0);
        checkOutput("t6_blk_ready_async", blk_ready, 1);
        checkOutput("t6_dout_async", dout, 0);
        checkOutput("t6_mode_err_cleared", mode_err, 0);
        expQ.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(M256, 640);
        applyStimulus(M128, 1344);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
